// File: rtl/munoc_activity_sample_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : munoc_activity_sample_scheduler_pkg
// Brief    : Shared FSM state encodings and index-width helper for the
//            activity sample scheduler.
// Revision : 1.0  initial release
// ============================================================================
package munoc_activity_sample_scheduler_pkg;

    // Scheduler states
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SELECT = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_REPORT = 2'd3;

    // Channel index width: max(1, clog2(n)) so a single channel still gets a bit
    function automatic int ch_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/munoc_activity_sample_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : munoc_activity_sample_scheduler_if
// Brief    : Result valid/ready port of the activity sample scheduler.
//            master = scheduler (producer), slave = consumer.
// Revision : 1.0  initial release
// ============================================================================
interface munoc_activity_sample_scheduler_if #(
    parameter int BW_CH_IDX = 2,
    parameter int BW_LEVEL  = 4
);
    logic                 result_valid;
    logic                 result_ready;
    logic [BW_CH_IDX-1:0] result_ch;
    logic [BW_LEVEL-1:0]  result_level;
    logic                 result_lost;

    modport master (
        output result_valid,
        output result_ch,
        output result_level,
        output result_lost,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_ch,
        input  result_level,
        input  result_lost,
        output result_ready
    );
endinterface
`default_nettype wire

// File: rtl/munoc_activity_window_counter.sv
`default_nettype none
// ============================================================================
// Module   : munoc_activity_window_counter
// Brief    : Window counter plus saturating busy counter for one sampling
//            window of 2^BW_WINDOW cycles. 'last' flags the final window
//            cycle; 'level' is the quantised count including the current
//            cycle's busy sample, so it can be captured on the 'last' cycle.
// Revision : 1.0  initial release
// ============================================================================
module munoc_activity_window_counter #(
    parameter int BW_WINDOW = 10,
    parameter int BW_LEVEL  = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                clear,
    input  wire logic                run,
    input  wire logic                busy,
    output logic                     last,
    output logic [BW_LEVEL-1:0]      level
);

    logic [BW_WINDOW-1:0] r_win_cnt;
    logic [BW_WINDOW-1:0] r_busy_cnt;
    logic [BW_WINDOW-1:0] w_busy_nxt;

    // Next busy count: count busy cycles, hold at all-ones (a fully busy window overflows by one)
    always_comb begin
        w_busy_nxt = r_busy_cnt;
        if (run && busy && (r_busy_cnt != '1)) begin
            w_busy_nxt = r_busy_cnt + BW_WINDOW'(1);
        end
    end

    assign last  = run && (r_win_cnt == '1);
    assign level = w_busy_nxt[BW_WINDOW-1 -: BW_LEVEL];

    // Counters advance only while the window runs; cleared before each new window
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_win_cnt  <= '0;
            r_busy_cnt <= '0;
        end else if (run) begin
            r_win_cnt  <= r_win_cnt + BW_WINDOW'(1);
            r_busy_cnt <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/munoc_activity_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : munoc_activity_sample_scheduler
// Brief    : Time-multiplexes one windowed activity sampler across NUM_CH
//            NoC channels in round-robin order and reports a quantised
//            utilisation level per channel on a valid/ready port.
//            Optional macro MUNOC_ACTIVITY_OVERWRITE_EN: results go to an
//            output register that is overwritten when not consumed, so
//            sampling never stalls; result_lost flags each overwrite.
// Revision : 1.0  initial release
// ============================================================================
module munoc_activity_sample_scheduler
    import munoc_activity_sample_scheduler_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int BW_WINDOW = 10,
    parameter  int BW_LEVEL  = 4,
    localparam int BW_CH_IDX = ch_idx_width(NUM_CH)
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   enable,
    input  wire logic [NUM_CH-1:0]      ch_mask,
    input  wire logic [NUM_CH-1:0]      busy_vec,
    munoc_activity_sample_scheduler_if.master res_if,
    output logic                        sampling,
    output logic [BW_CH_IDX-1:0]        active_ch
);

    logic [1:0]           r_state;
    logic [BW_CH_IDX-1:0] r_active_ch;
    logic [BW_CH_IDX-1:0] r_last_done;
    logic                 r_result_valid;
    logic [BW_CH_IDX-1:0] r_result_ch;
    logic [BW_LEVEL-1:0]  r_result_level;

    logic                 w_any;
    logic                 w_run;
    logic                 w_clear;
    logic                 w_last;
    logic                 w_accept;
    logic [BW_LEVEL-1:0]  w_level;
    logic                 w_hi_ok;
    logic [BW_CH_IDX-1:0] w_hi_ch;
    logic                 w_lo_ok;
    logic [BW_CH_IDX-1:0] w_lo_ch;
    logic                 w_pick_ok;
    logic [BW_CH_IDX-1:0] w_pick_ch;

    assign w_any    = |ch_mask;
    // Dropping enable mid-window aborts it, so the counters must not advance then
    assign w_run    = (r_state == c_ST_SAMPLE) && enable;
    assign w_clear  = (r_state == c_ST_SELECT);
    assign w_accept = r_result_valid && res_if.result_ready;

    munoc_activity_window_counter #(
        .BW_WINDOW (BW_WINDOW),
        .BW_LEVEL  (BW_LEVEL)
    ) u_win (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .run   (w_run),
        .busy  (busy_vec[r_active_ch]),
        .last  (w_last),
        .level (w_level)
    );

    // Round-robin pick: lowest set bit above last_done, else wrap to lowest set bit
    always_comb begin
        w_hi_ok = 1'b0;
        w_hi_ch = '0;
        w_lo_ok = 1'b0;
        w_lo_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                if (BW_CH_IDX'(i) > r_last_done) begin
                    w_hi_ok = 1'b1;
                    w_hi_ch = BW_CH_IDX'(i);
                end else begin
                    w_lo_ok = 1'b1;
                    w_lo_ch = BW_CH_IDX'(i);
                end
            end
        end
        w_pick_ok = w_hi_ok || w_lo_ok;
        w_pick_ch = w_hi_ok ? w_hi_ch : w_lo_ch;
    end

    // Scheduler FSM: IDLE -> SELECT -> SAMPLE -> (REPORT) -> SELECT/IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_active_ch <= '0;
            r_last_done <= BW_CH_IDX'(NUM_CH - 1);
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (enable && w_any) begin
                        r_state <= c_ST_SELECT;
                    end
                end
                c_ST_SELECT: begin
                    if (enable && w_pick_ok) begin
                        r_active_ch <= w_pick_ch;
                        r_state     <= c_ST_SAMPLE;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_SAMPLE: begin
                    // An aborted window leaves last_done alone so the same channel is retried
                    if (!enable) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_last) begin
                        r_last_done <= r_active_ch;
`ifdef MUNOC_ACTIVITY_OVERWRITE_EN
                        r_state     <= c_ST_SELECT;
`else
                        r_state     <= c_ST_REPORT;
`endif
                    end
                end
                c_ST_REPORT: begin
                    if (w_accept) begin
                        r_state <= (enable && w_any) ? c_ST_SELECT : c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Result register: loaded at window end, cleared when consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_valid <= 1'b0;
            r_result_ch    <= '0;
            r_result_level <= '0;
        end else if (w_last) begin
            r_result_valid <= 1'b1;
            r_result_ch    <= r_active_ch;
            r_result_level <= w_level;
        end else if (w_accept) begin
            r_result_valid <= 1'b0;
        end
    end

`ifdef MUNOC_ACTIVITY_OVERWRITE_EN
    logic r_result_lost;

    // Loss pulse: an unconsumed result is replaced; a same-cycle accept is not a loss
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_lost <= 1'b0;
        end else begin
            r_result_lost <= w_last && r_result_valid && !res_if.result_ready;
        end
    end

    assign res_if.result_lost = r_result_lost;
`else
    assign res_if.result_lost = 1'b0;
`endif

    assign res_if.result_valid = r_result_valid;
    assign res_if.result_ch    = r_result_ch;
    assign res_if.result_level = r_result_level;
    assign sampling            = (r_state == c_ST_SAMPLE);
    assign active_ch           = r_active_ch;

endmodule
`default_nettype wire

// File: tb/tb_munoc_activity_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_munoc_activity_sample_scheduler
// Brief    : Self-checking bench for munoc_activity_sample_scheduler with
//            NUM_CH=4, BW_WINDOW=4, BW_LEVEL=2. Expected results come from a
//            window-schedule model (round-robin order, busy history sums).
//            Honours MUNOC_ACTIVITY_OVERWRITE_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_munoc_activity_sample_scheduler;

    localparam int NUM_CH    = 4;
    localparam int BW_WINDOW = 4;
    localparam int BW_LEVEL  = 2;
    localparam int WIN       = 1 << BW_WINDOW;
`ifdef MUNOC_ACTIVITY_OVERWRITE_EN
    localparam int PERIOD    = WIN + 1;
`else
    localparam int PERIOD    = WIN + 2;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       enable   = 1'b0;
    logic [3:0] ch_mask  = 4'b0000;
    logic [3:0] busy_vec = 4'b0000;
    logic       sampling;
    logic [1:0] active_ch;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] hist [0:255];

    munoc_activity_sample_scheduler_if #(.BW_CH_IDX(2), .BW_LEVEL(BW_LEVEL)) res_if ();

    munoc_activity_sample_scheduler #(
        .NUM_CH    (NUM_CH),
        .BW_WINDOW (BW_WINDOW),
        .BW_LEVEL  (BW_LEVEL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ch_mask   (ch_mask),
        .busy_vec  (busy_vec),
        .res_if    (res_if),
        .sampling  (sampling),
        .active_ch (active_ch)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Next channel in round-robin order after 'last'
    function automatic int next_ch(input int last, input logic [3:0] m);
        for (int k = 1; k <= NUM_CH; k++) begin
            if (m[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        end
        return -1;
    endfunction

    // Utilisation level from a raw busy-cycle count
    function automatic int exp_level(input int cnt);
        int c;
        c = (cnt > WIN - 1) ? WIN - 1 : cnt;
        return c / (1 << (BW_WINDOW - BW_LEVEL));
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_val("rst_valid",  int'(res_if.result_valid), 0);
        check_val("rst_ch",     int'(res_if.result_ch),    0);
        check_val("rst_level",  int'(res_if.result_level), 0);
        check_val("rst_lost",   int'(res_if.result_lost),  0);
        check_val("rst_sampling", int'(sampling),          0);
        check_val("rst_active", int'(active_ch),           0);
    endtask

    // Run nwin back-to-back windows from IDLE with ready held high.
    // mode 0: random busy OR'd with cval; 1: constant cval; 2: cval on odd cycles.
    task automatic run_round(input logic [3:0] mask, input int nwin, input int mode,
                             input logic [3:0] cval);
        int chs [0:15];
        int cur;
        int total;
        int ph;
        int k;
        int cnt;
        logic [3:0] b;
        cur = NUM_CH - 1;
        for (int w = 0; w < nwin; w++) begin
            cur = next_ch(cur, mask);
            chs[w] = cur;
        end
        total = 2 + PERIOD * nwin;
        enable = 1'b1;
        ch_mask = mask;
        res_if.result_ready = 1'b1;
        for (int off = 0; off < total; off++) begin
            if (off >= 2) begin
                ph = (off - 2) % PERIOD;
                k  = (off - 2) / PERIOD;
                check_val("rr_valid", int'(res_if.result_valid), int'(ph == WIN));
                if (ph == WIN) begin
                    cnt = 0;
                    for (int t = 0; t < WIN; t++) cnt += int'(hist[off - WIN + t][chs[k]]);
                    check_val("rr_ch",    int'(res_if.result_ch),    chs[k]);
                    check_val("rr_level", int'(res_if.result_level), exp_level(cnt));
                end
                if (ph == WIN / 2) begin
                    check_val("rr_sampling", int'(sampling),  1);
                    check_val("rr_active",   int'(active_ch), chs[k]);
                end
            end else begin
                check_val("rr_valid_pre", int'(res_if.result_valid), 0);
            end
            case (mode)
                0:       b = 4'($urandom) | cval;
                1:       b = cval;
                default: b = (off % 2 == 1) ? cval : 4'b0000;
            endcase
            hist[off] = b;
            busy_vec  = b;
            tick;
        end
        enable = 1'b0;
    endtask

    initial begin
        int cnt;
        int lvl;
        logic [3:0] m;
        logic [3:0] b;

        res_if.result_ready = 1'b1;
        do_reset;

        // Round robin with saturation: expect (0,3),(2,0),(0,3)
        run_round(4'b0101, 3, 1, 4'b0001);
        do_reset;

        // Half duty on channel 1: 8 busy cycles -> level 2
        run_round(4'b0010, 1, 2, 4'b0010);

        // Randomised masks and busy traffic
        for (int r = 0; r < 4; r++) begin
            m = 4'($urandom_range(1, 15));
            b = 4'($urandom) & 4'($urandom);
            do_reset;
            run_round(m, 5, 0, b);
        end

`ifndef MUNOC_ACTIVITY_OVERWRITE_EN
        // Backpressure: result held stable while the consumer stalls
        do_reset;
        enable = 1'b1;
        ch_mask = 4'b0010;
        res_if.result_ready = 1'b0;
        cnt = 0;
        for (int off = 0; off < 2 + WIN; off++) begin
            b = 4'($urandom);
            if (off >= 2) cnt += int'(b[1]);
            busy_vec = b;
            tick;
        end
        lvl = exp_level(cnt);
        for (int h = 0; h < 40; h++) begin
            check_val("bp_valid",    int'(res_if.result_valid), 1);
            check_val("bp_ch",       int'(res_if.result_ch),    1);
            check_val("bp_level",    int'(res_if.result_level), lvl);
            check_val("bp_sampling", int'(sampling),            0);
            busy_vec = 4'($urandom);
            tick;
        end
        res_if.result_ready = 1'b1;
        tick;
        check_val("bp_valid_drop", int'(res_if.result_valid), 0);
        check_val("bp_select",     int'(sampling),            0);
        tick;
        check_val("bp_resample",   int'(sampling),            1);
        check_val("bp_resample_ch", int'(active_ch),          1);

        // Reset while a result is pending, then restart with mask 1110
        do_reset;
        enable = 1'b1;
        ch_mask = 4'b1110;
        res_if.result_ready = 1'b0;
        for (int off = 0; off < 2 + WIN; off++) begin
            busy_vec = 4'($urandom);
            tick;
        end
        check_val("rr_pending_valid", int'(res_if.result_valid), 1);
        do_reset;
        run_round(4'b1110, 2, 0, 4'b0000);
`endif

        // Abort: second window (ch3) aborted at window cycle 7, then retried
        do_reset;
        enable = 1'b1;
        ch_mask = 4'b1001;
        res_if.result_ready = 1'b1;
        for (int off = 0; off < 2 + PERIOD + 8; off++) begin
            if (off == 2 + WIN) begin
                check_val("ab_first_valid", int'(res_if.result_valid), 1);
                check_val("ab_first_ch",    int'(res_if.result_ch),    0);
            end
            if (off == 2 + PERIOD + 4) begin
                check_val("ab_sampling", int'(sampling),  1);
                check_val("ab_active",   int'(active_ch), 3);
            end
            busy_vec = 4'($urandom);
            if (off == 2 + PERIOD + 7) enable = 1'b0;
            tick;
        end
        for (int h = 0; h < 20; h++) begin
            check_val("ab_no_valid",    int'(res_if.result_valid), 0);
            check_val("ab_no_sampling", int'(sampling),            0);
            tick;
        end
        enable = 1'b1;
        tick;
        tick;
        check_val("ab_retry_sampling", int'(sampling),  1);
        check_val("ab_retry_ch",       int'(active_ch), 3);

`ifdef MUNOC_ACTIVITY_OVERWRITE_EN
        // Overwrite: two windows with no consumer; second load loses the first
        do_reset;
        enable = 1'b1;
        ch_mask = 4'b0001;
        res_if.result_ready = 1'b0;
        for (int off = 0; off < 2 + 2 * PERIOD + 2; off++) begin
            if (off == 2 + WIN) begin
                check_val("ow_first_valid", int'(res_if.result_valid), 1);
                check_val("ow_first_level", int'(res_if.result_level), 3);
                check_val("ow_first_lost",  int'(res_if.result_lost),  0);
            end
            if (off == 2 + PERIOD + WIN) begin
                check_val("ow_second_valid", int'(res_if.result_valid), 1);
                check_val("ow_second_ch",    int'(res_if.result_ch),    0);
                check_val("ow_second_level", int'(res_if.result_level), 0);
                check_val("ow_second_lost",  int'(res_if.result_lost),  1);
            end
            if (off == 2 + PERIOD + WIN + 1) begin
                check_val("ow_lost_pulse", int'(res_if.result_lost), 0);
            end
            busy_vec = (off < 2 + WIN) ? 4'b0001 : 4'b0000;
            tick;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
